// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: status word layout,
// the widest supported button vector and a small popcount helper.
package btn_pkg;

    localparam int unsigned LEVEL_LSB   = 0;
    localparam int unsigned PRESS_LSB   = 8;
    localparam int unsigned RELEASE_LSB = 16;
    localparam int unsigned COUNT_LSB   = 24;

    localparam int unsigned MAX_BTN = 8;

    // Number of set bits in a button vector (0..MAX_BTN).
    function automatic logic [3:0] popcount(input logic [MAX_BTN-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < MAX_BTN; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: two-flop synchroniser, polarity fix-up and a
// stability counter that only accepts a new level after it has been seen for
// DEBOUNCE_CYCLES consecutive cycles. Press/release are one-cycle pulses that
// line up with the cycle the accepted level changes.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o,
    output logic press_o,
    output logic release_o
);

    // Raw level of a released button; the synchroniser resets to it so that
    // leaving reset never looks like a press.
    localparam logic             RawIdle = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             sync;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RawIdle;
            sync_q <= RawIdle;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    // Internal polarity: 1 always means pressed.
    assign sync = sync_q ^ ACTIVE_LOW;

    // Count consecutive disagreeing samples; accept on the last one.
    always_comb begin
        cnt_d     = '0;
        stable_d  = stable_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync != stable_q) begin
            if (cnt_q == CntLast) begin
                stable_d  = sync;
                press_d   = sync;
                release_d = ~sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state and registered event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign stable_o  = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end for the butao PIO: debounces NUM_BTN raw keys and
// packs clean levels, sticky press/release flags and an 8-bit press counter
// into a registered 32-bit status word. Flags and counter are cleared by
// rising edges on software-driven clear levels.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw_i,
    input  logic [NUM_BTN-1:0] flag_clr_i,
    input  logic               cnt_clr_i,
    output logic [31:0]        status_o,
    output logic [NUM_BTN-1:0] press_pulse_o
);

    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] release_ev;

    logic [NUM_BTN-1:0] flag_clr_q, flag_clr_prev_q;
    logic               cnt_clr_q, cnt_clr_prev_q;
    logic [NUM_BTN-1:0] flag_fire;
    logic               cnt_fire;

    logic [NUM_BTN-1:0] press_flag_q, press_flag_d;
    logic [NUM_BTN-1:0] release_flag_q, release_flag_d;
    logic [7:0]         count_q, count_d;
    logic [31:0]        status_q, status_d;

    logic [MAX_BTN-1:0] press_ext;
    logic [MAX_BTN-1:0] stable_ext;
    logic [MAX_BTN-1:0] press_flag_ext;
    logic [MAX_BTN-1:0] release_flag_ext;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (btn_raw_i[g]),
            .stable_o (stable[g]),
            .press_o  (press[g]),
            .release_o(release_ev[g])
        );
    end

    // Register the clear levels and keep the previous sample for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_clr_q      <= '0;
            flag_clr_prev_q <= '0;
            cnt_clr_q       <= 1'b0;
            cnt_clr_prev_q  <= 1'b0;
        end else begin
            flag_clr_q      <= flag_clr_i;
            flag_clr_prev_q <= flag_clr_q;
            cnt_clr_q       <= cnt_clr_i;
            cnt_clr_prev_q  <= cnt_clr_q;
        end
    end

    assign flag_fire = flag_clr_q & ~flag_clr_prev_q;
    assign cnt_fire  = cnt_clr_q & ~cnt_clr_prev_q;

    // Widen per-button vectors to a full status byte; unused bits stay 0.
    always_comb begin
        press_ext                       = '0;
        stable_ext                      = '0;
        press_flag_ext                  = '0;
        release_flag_ext                = '0;
        press_ext[NUM_BTN-1:0]          = press;
        stable_ext[NUM_BTN-1:0]         = stable;
        press_flag_ext[NUM_BTN-1:0]     = press_flag_d;
        release_flag_ext[NUM_BTN-1:0]   = release_flag_d;
    end

    // Sticky flags (set beats clear), press counter and status packing.
    always_comb begin
        press_flag_d   = (press_flag_q & ~flag_fire) | press;
        release_flag_d = (release_flag_q & ~flag_fire) | release_ev;
        // A clear edge loads this cycle's presses so none are lost.
        count_d        = (cnt_fire ? 8'd0 : count_q) + {4'd0, popcount(press_ext)};
        status_d                          = '0;
        status_d[LEVEL_LSB +: MAX_BTN]    = stable_ext;
        status_d[PRESS_LSB +: MAX_BTN]    = press_flag_ext;
        status_d[RELEASE_LSB +: MAX_BTN]  = release_flag_ext;
        status_d[COUNT_LSB +: 8]          = count_d;
    end

    // Flag, counter and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_flag_q   <= '0;
            release_flag_q <= '0;
            count_q        <= '0;
            status_q       <= '0;
        end else begin
            press_flag_q   <= press_flag_d;
            release_flag_q <= release_flag_d;
            count_q        <= count_d;
            status_q       <= status_d;
        end
    end

    assign status_o      = status_q;
    assign press_pulse_o = press;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4, NUM_BTN=4, active-low
// keys. A reference model predicts status/pulse for every clock and queues
// the prediction; a monitor pops and compares each cycle. Directed steps add
// absolute checks on the documented scenarios.
module tb_button_conditioner;

    localparam int unsigned N  = 4;
    localparam int unsigned D  = 4;
    localparam bit          AL = 1'b1;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  btn_raw_i;
    logic [N-1:0]  flag_clr_i;
    logic          cnt_clr_i;
    logic [31:0]   status_o;
    logic [N-1:0]  press_pulse_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN        (N),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (AL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw_i    (btn_raw_i),
        .flag_clr_i   (flag_clr_i),
        .cnt_clr_i    (cnt_clr_i),
        .status_o     (status_o),
        .press_pulse_o(press_pulse_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state. Raw pins reach the debouncer two edges late;
    // a level is accepted once the last D synchronised samples all disagree
    // with the accepted level. Clears act on a 0->1 of the once-registered
    // level; events are folded into flags/counter one clock after they occur.
    logic [N-1:0]    m_r1, m_r2, m_f1, m_f2;
    logic            m_c1, m_c2;
    logic [N-1:0]    m_hist[$];
    logic [N-1:0]    m_stable, m_press, m_rel, m_pflag, m_rflag;
    logic [7:0]      m_count;
    logic [32+N-1:0] exp_q[$];

    always @(posedge clk) begin
        logic [N-1:0] f_fire, sync_now, flip;
        logic         c_fire, all_diff;
        logic [31:0]  exp_status;
        if (reset) begin
            m_r1 = {N{AL}}; m_r2 = {N{AL}};
            m_f1 = '0; m_f2 = '0; m_c1 = 1'b0; m_c2 = 1'b0;
            m_hist.delete();
            m_stable = '0; m_press = '0; m_rel = '0;
            m_pflag = '0; m_rflag = '0; m_count = '0;
            exp_q.push_back('0);
        end else begin
            f_fire  = m_f1 & ~m_f2;
            c_fire  = m_c1 & ~m_c2;
            m_pflag = (m_pflag & ~f_fire) | m_press;
            m_rflag = (m_rflag & ~f_fire) | m_rel;
            m_count = (c_fire ? 8'd0 : m_count) + 8'($countones(m_press));
            exp_status = {m_count, 8'(m_rflag), 8'(m_pflag), 8'(m_stable)};
            sync_now = m_r2 ^ {N{AL}};
            m_hist.push_back(sync_now);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            flip = '0;
            for (int n = 0; n < N; n++) begin
                all_diff = (m_hist.size() == D);
                foreach (m_hist[i]) if (m_hist[i][n] == m_stable[n]) all_diff = 1'b0;
                flip[n] = all_diff;
            end
            m_press  = flip & ~m_stable;
            m_rel    = flip & m_stable;
            m_stable = m_stable ^ flip;
            m_r2 = m_r1; m_r1 = btn_raw_i;
            m_f2 = m_f1; m_f1 = flag_clr_i;
            m_c2 = m_c1; m_c1 = cnt_clr_i;
            exp_q.push_back({exp_status, m_press});
        end
    end

    // Monitor: one prediction per clock, compared away from the active edge.
    always @(negedge clk) begin
        logic [32+N-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_status", status_o, e[32+N-1:N]);
            check("sb_pulse", 32'(press_pulse_o), 32'(e[N-1:0]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int need, k;
        reset = 1'b1; btn_raw_i = '1; flag_clr_i = '0; cnt_clr_i = 1'b0;

        // Reset state, during and after reset.
        tick(3);
        check("rst_status_during", status_o, 32'h0);
        check("rst_pulse_during", 32'(press_pulse_o), 32'h0);
        reset = 1'b0;
        tick(4);
        check("rst_status_after", status_o, 32'h0);
        check("rst_pulse_after", 32'(press_pulse_o), 32'h0);

        // Clean press of button 0: pulse 6 clocks later, status one after.
        btn_raw_i[0] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 5) check("press0_early", 32'(press_pulse_o), 32'h0);
            if (c == 6) check("press0_pulse", 32'(press_pulse_o), 32'h1);
            if (c == 7) begin
                check("press0_pulse_once", 32'(press_pulse_o), 32'h0);
                check("press0_status", status_o, 32'h0100_0101);
            end
        end

        // Bounce on button 1 shorter than the debounce window.
        btn_raw_i[1] = 1'b0;
        tick(3);
        btn_raw_i[1] = 1'b1;
        tick(8);
        check("bounce_status", status_o, 32'h0100_0101);

        // Buttons 2 and 3 together.
        btn_raw_i[3:2] = 2'b00;
        tick(8);
        check("dual_count", 32'(status_o[31:24]), 32'h3);
        check("dual_flags", 32'(status_o[11:10]), 32'h3);
        check("dual_status", status_o, 32'h0300_0D0D);

        // Release everything, then clear flag 0 with a held level.
        btn_raw_i = '1;
        tick(8);
        check("release_status", status_o, 32'h030D_0D00);
        flag_clr_i[0] = 1'b1;
        tick(4);
        check("clr0_cleared", 32'(status_o[16:8]), 32'h0C);
        btn_raw_i[0] = 1'b0;
        tick(8);
        check("clr0_reset_by_press", 32'(status_o[8]), 32'h1);
        tick(4);
        check("clr0_stays_set", 32'(status_o[8]), 32'h1);
        flag_clr_i[0] = 1'b0;
        btn_raw_i = '1;
        tick(8);

        // Drive the counter to 0xFF, then one more press wraps it.
        while (m_count != 8'hFF) begin
            need = 255 - int'(m_count);
            k = (need > 4) ? 4 : need;
            btn_raw_i = ~N'((1 << k) - 1);
            tick(8);
            btn_raw_i = '1;
            tick(8);
        end
        check("count_ff", 32'(status_o[31:24]), 32'hFF);
        btn_raw_i[0] = 1'b0;
        tick(8);
        check("count_wrap", 32'(status_o[31:24]), 32'h00);
        btn_raw_i = '1;
        tick(8);
        btn_raw_i[1] = 1'b0;
        tick(8);
        check("count_one", 32'(status_o[31:24]), 32'h01);
        btn_raw_i = '1;
        tick(8);

        // Counter clear edge lands in the same cycle as a press.
        btn_raw_i[2] = 1'b0;
        tick(5);
        cnt_clr_i = 1'b1;
        tick(4);
        check("clr_with_press", 32'(status_o[31:24]), 32'h01);
        cnt_clr_i = 1'b0;
        btn_raw_i = '1;
        tick(8);

        // Randomised phase: held levels of random length, clears, resets.
        for (int s = 0; s < 400; s++) begin
            btn_raw_i = N'($urandom);
            if ($urandom_range(0, 3) == 0) flag_clr_i = N'($urandom);
            if ($urandom_range(0, 5) == 0) cnt_clr_i = ~cnt_clr_i;
            if ($urandom_range(0, 60) == 0) reset = 1'b1;
            tick(1);
            reset = 1'b0;
            tick(int'($urandom_range(0, 9)));
        end
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
